// File: rtl/norm_shift_sched_if.sv
`default_nettype none
// ============================================================================
// Module   : norm_shift_sched_if
// Brief    : Request/response bundle between requesters and the shared
//            normalizing shifter.
// Revision : 1.0 - initial release
// ============================================================================
interface norm_shift_sched_if #(
    parameter int NREQ = 4,
    parameter int DW   = 16,
    parameter int IDW  = 2
);
    logic [NREQ-1:0]    req_valid;
    logic [NREQ*DW-1:0] req_data;
    logic [NREQ-1:0]    req_ready;
    logic               out_valid;
    logic               out_ready;
    logic [DW-1:0]      out_mant;
    logic [4:0]         out_shift;
    logic [IDW-1:0]     out_id;
    logic               out_hit;
    logic               busy;

    modport master (
        output req_valid, req_data, out_ready,
        input  req_ready, out_valid, out_mant, out_shift, out_id, out_hit, busy
    );

    modport slave (
        input  req_valid, req_data, out_ready,
        output req_ready, out_valid, out_mant, out_shift, out_id, out_hit, busy
    );
endinterface
`default_nettype wire

// File: rtl/norm_shift_sched.sv
`default_nettype none
// ============================================================================
// Module   : norm_shift_sched
// Brief    : Round-robin shared sequential shifter that finds the smallest
//            right shift placing x strictly inside (LO,HI).
// Revision : 1.0 - initial release
// ============================================================================
module norm_shift_sched #(
    parameter int            NREQ      = 4,
    parameter int            DW        = 16,
    parameter int            MAX_SHIFT = 8,
    parameter logic [DW-1:0] LO        = 16'h0080,
    parameter logic [DW-1:0] HI        = 16'h0100
) (
    input  logic              clk,
    input  logic              rst_n,
    norm_shift_sched_if.slave bus
);
    localparam int IDW = (NREQ > 1) ? $clog2(NREQ) : 1;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_SHIFT = 2'd1;
    localparam logic [1:0] ST_DONE  = 2'd2;

    logic [1:0]     state_q, state_d;
    logic [IDW-1:0] rr_ptr_q, rr_ptr_d;
    logic [IDW-1:0] out_id_q, out_id_d;
    logic [DW-1:0]  orig_q, orig_d;
    logic [DW-1:0]  work_q, work_d;
    logic [DW-1:0]  mant_q, mant_d;
    logic [4:0]     cnt_q, cnt_d;
    logic [4:0]     shift_q, shift_d;
    logic           hit_q, hit_d;

    logic [IDW-1:0] grant;
    logic           found;
    logic [DW-1:0]  sel_data;
    logic [IDW:0]   scan_sum;
    logic [IDW-1:0] scan_idx;

    logic [DW-1:0]  nxt;
    logic [4:0]     c1;
    logic           win_hit;
    logic           give_up;

    assign nxt     = work_q >> 1;
    assign c1      = cnt_q + 5'd1;
    assign win_hit = (nxt > LO) && (nxt < HI);
    // Shifting only shrinks the value, so once at or below LO no later shift can hit.
    assign give_up = (nxt <= LO) || (c1 == 5'(MAX_SHIFT));

    // Round-robin scan starting at rr_ptr; the first valid requester wins.
    always_comb begin
        grant    = '0;
        found    = 1'b0;
        scan_sum = '0;
        scan_idx = '0;
        for (int off = 0; off < NREQ; off++) begin
            scan_sum = {1'b0, rr_ptr_q} + (IDW+1)'(off);
            if (scan_sum >= (IDW+1)'(NREQ)) begin
                scan_sum = scan_sum - (IDW+1)'(NREQ);
            end
            scan_idx = scan_sum[IDW-1:0];
            if (!found && bus.req_valid[scan_idx]) begin
                grant = scan_idx;
                found = 1'b1;
            end
        end
    end

    always_comb begin
        sel_data = '0;
        for (int k = 0; k < NREQ; k++) begin
            if (grant == IDW'(k)) begin
                sel_data = bus.req_data[k*DW +: DW];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            rr_ptr_q <= '0;
            out_id_q <= '0;
            orig_q   <= '0;
            work_q   <= '0;
            mant_q   <= '0;
            cnt_q    <= '0;
            shift_q  <= '0;
            hit_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            rr_ptr_q <= rr_ptr_d;
            out_id_q <= out_id_d;
            orig_q   <= orig_d;
            work_q   <= work_d;
            mant_q   <= mant_d;
            cnt_q    <= cnt_d;
            shift_q  <= shift_d;
            hit_q    <= hit_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        rr_ptr_d = rr_ptr_q;
        out_id_d = out_id_q;
        orig_d   = orig_q;
        work_d   = work_q;
        mant_d   = mant_q;
        cnt_d    = cnt_q;
        shift_d  = shift_q;
        hit_d    = hit_q;
        case (state_q)
            ST_IDLE: begin
                if (found) begin
                    orig_d   = sel_data;
                    work_d   = sel_data;
                    cnt_d    = 5'd0;
                    out_id_d = grant;
                    state_d  = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                if (win_hit) begin
                    mant_d  = nxt;
                    shift_d = c1;
                    hit_d   = 1'b1;
                    state_d = ST_DONE;
                end else if (give_up) begin
                    mant_d  = orig_q;
                    shift_d = 5'd0;
                    hit_d   = 1'b0;
                    state_d = ST_DONE;
                end else begin
                    work_d = nxt;
                    cnt_d  = c1;
                end
            end
            ST_DONE: begin
                if (bus.out_ready) begin
                    rr_ptr_d = (out_id_q == IDW'(NREQ-1)) ? '0 : out_id_q + IDW'(1);
                    state_d  = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        bus.req_ready = '0;
        if ((state_q == ST_IDLE) && found) begin
            bus.req_ready[grant] = 1'b1;
        end
        bus.out_valid = (state_q == ST_DONE);
        bus.busy      = (state_q != ST_IDLE);
    end

    assign bus.out_mant  = mant_q;
    assign bus.out_shift = shift_q;
    assign bus.out_id    = out_id_q;
    assign bus.out_hit   = hit_q;
endmodule
`default_nettype wire

// File: tb/tb_norm_shift_sched.sv
`default_nettype none
// ============================================================================
// Module   : tb_norm_shift_sched
// Brief    : Directed-vector scoreboard bench for norm_shift_sched.
// Revision : 1.0 - initial release
// ============================================================================
module tb_norm_shift_sched;
    logic clk;
    logic rst_n;

    norm_shift_sched_if #(.NREQ(4), .DW(16), .IDW(2)) bus ();

    norm_shift_sched #(
        .NREQ(4), .DW(16), .MAX_SHIFT(8), .LO(16'h0080), .HI(16'h0100)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    typedef struct {
        logic [1:0]  id;
        logic [15:0] mant;
        logic [4:0]  shift;
        logic        hit;
        int          lat;
    } exp_t;

    exp_t sb[$];
    int   n_chk  = 0;
    int   n_pass = 0;
    int   cyc    = 0;
    int   acc_cyc = 0;
    logic prev_v = 1'b0;

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_chk++;
        if (act !== req) $display("FAIL %s actual=%0h required=%0h", name, act, req);
        else n_pass++;
    endtask

    task automatic push_exp(input logic [1:0] id, input logic [15:0] mant,
                            input logic [4:0] shift, input logic hit, input int lat);
        exp_t e;
        e.id = id; e.mant = mant; e.shift = shift; e.hit = hit; e.lat = lat;
        sb.push_back(e);
    endtask

    task automatic wait_accept(input int k);
        int n = 0;
        @(negedge clk);
        while (!bus.req_ready[k] && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (!bus.req_ready[k]) chk("accept_timeout", 32'd0, 32'd1);
        else begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic wait_drain();
        int n = 0;
        while (sb.size() != 0 && n < 500) begin
            @(negedge clk);
            n++;
        end
        if (sb.size() != 0) chk("drain_timeout", sb.size(), 0);
        @(posedge clk);
        #1;
    endtask

    // Single request; req_data is scrambled after accept to prove the value was latched.
    task automatic single(input int k, input logic [15:0] x, input logic [15:0] mant,
                          input logic [4:0] shift, input logic hit, input int lat);
        push_exp(2'(k), mant, shift, hit, lat);
        bus.req_data[k*16 +: 16] = x;
        bus.req_valid[k] = 1'b1;
        wait_accept(k);
        bus.req_valid[k] = 1'b0;
        bus.req_data[k*16 +: 16] = 16'h0000;
        wait_drain();
    endtask

    task automatic reset_check(input string tag);
        chk({tag, "_valid"}, bus.out_valid, 0);
        chk({tag, "_busy"},  bus.busy, 0);
        chk({tag, "_mant"},  bus.out_mant, 0);
        chk({tag, "_shift"}, bus.out_shift, 0);
        chk({tag, "_id"},    bus.out_id, 0);
        chk({tag, "_hit"},   bus.out_hit, 0);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (!rst_n) begin
            prev_v = 1'b0;
        end else begin
            if (bus.req_ready != 4'b0000) begin
                chk("ready_onehot_idle", {31'b0, $onehot(bus.req_ready) && !bus.busy}, 1);
                acc_cyc = cyc + 1;
            end
            if (bus.out_valid && !prev_v) begin
                if (sb.size() == 0) chk("unexpected_result", 1, 0);
                else chk("latency", cyc - acc_cyc, sb[0].lat);
            end
            if (bus.out_valid && bus.out_ready && sb.size() != 0) begin
                e = sb.pop_front();
                chk("out_id",    bus.out_id,    e.id);
                chk("out_mant",  bus.out_mant,  e.mant);
                chk("out_shift", bus.out_shift, e.shift);
                chk("out_hit",   bus.out_hit,   e.hit);
            end
            prev_v = bus.out_valid;
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        bus.req_valid = '0;
        bus.req_data  = '0;
        bus.out_ready = 1'b1;
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        reset_check("rst0");
        rst_n = 1'b1;

        single(0, 16'hFFFF, 16'h00FF, 5'd8, 1'b1, 8);
        single(1, 16'h0180, 16'h00C0, 5'd1, 1'b1, 1);
        single(2, 16'h0101, 16'h0101, 5'd0, 1'b0, 1);
        single(3, 16'h0000, 16'h0000, 5'd0, 1'b0, 1);
        single(0, 16'h0050, 16'h0050, 5'd0, 1'b0, 1);
        single(1, 16'h8000, 16'h8000, 5'd0, 1'b0, 8);
        single(2, 16'h0200, 16'h0200, 5'd0, 1'b0, 2);
        single(3, 16'h0300, 16'h00C0, 5'd2, 1'b1, 2);
        single(0, 16'h01FF, 16'h00FF, 5'd1, 1'b1, 1);

        // All requesters valid: grant order must rotate 0,1,2,3,0,1,2,3.
        do_reset();
        for (int r = 0; r < 2; r++) begin
            push_exp(2'd0, 16'h00C0, 5'd1, 1'b1, 1);
            push_exp(2'd1, 16'h0400, 5'd0, 1'b0, 3);
            push_exp(2'd2, 16'h0091, 5'd5, 1'b1, 5);
            push_exp(2'd3, 16'h00FF, 5'd8, 1'b1, 8);
        end
        bus.req_data  = {16'hFFFF, 16'h1234, 16'h0400, 16'h0180};
        bus.req_valid = 4'b1111;
        for (int i = 0; i < 8; i++) wait_accept(i % 4);
        bus.req_valid = 4'b0000;
        wait_drain();

        // Consumer stall with a competing request pending.
        push_exp(2'd2, 16'h00C0, 5'd1, 1'b1, 1);
        push_exp(2'd1, 16'h0050, 5'd0, 1'b0, 1);
        bus.out_ready = 1'b0;
        bus.req_data[2*16 +: 16] = 16'h0180;
        bus.req_valid[2] = 1'b1;
        wait_accept(2);
        bus.req_valid[2] = 1'b0;
        bus.req_data[1*16 +: 16] = 16'h0050;
        bus.req_valid[1] = 1'b1;
        n = 0;
        while (!bus.out_valid && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk("stall_valid_seen", bus.out_valid, 1);
        for (int i = 0; i < 5; i++) begin
            chk("stall_mant",  bus.out_mant, 16'h00C0);
            chk("stall_shift", bus.out_shift, 1);
            chk("stall_id",    bus.out_id, 2);
            chk("stall_valid", bus.out_valid, 1);
            chk("stall_noready", bus.req_ready, 0);
            @(negedge clk);
        end
        @(posedge clk);
        #1;
        bus.out_ready = 1'b1;
        @(posedge clk);
        #1;
        chk("release_idle_busy",  bus.busy, 0);
        chk("release_idle_valid", bus.out_valid, 0);
        chk("release_ready",      bus.req_ready, 4'b0010);
        wait_accept(1);
        bus.req_valid[1] = 1'b0;
        wait_drain();

        // Asynchronous reset during the third shift cycle discards the job.
        bus.req_data[0*16 +: 16] = 16'hFFFF;
        bus.req_valid[0] = 1'b1;
        wait_accept(0);
        bus.req_valid[0] = 1'b0;
        repeat (2) @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        reset_check("rst_mid");
        chk("rst_mid_ready", bus.req_ready, 0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;

        push_exp(2'd0, 16'h00C0, 5'd1, 1'b1, 1);
        push_exp(2'd1, 16'h0101, 5'd0, 1'b0, 1);
        bus.req_data[0*16 +: 16] = 16'h0180;
        bus.req_data[1*16 +: 16] = 16'h0101;
        bus.req_valid[1:0] = 2'b11;
        wait_accept(0);
        bus.req_valid[0] = 1'b0;
        wait_accept(1);
        bus.req_valid[1] = 1'b0;
        wait_drain();

        repeat (3) @(posedge clk);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
`default_nettype wire
